// File: rtl/slm_mem_pkg.sv
// -----------------------------------------------------------------------------
// slm_mem_pkg
// Shared definitions for the SDRAM frame store. The stream writer and the
// VGA reader both import this package so they agree on the address layout.
//   - Default raster size (H_ACTIVE_DEFAULT x V_ACTIVE_DEFAULT).
//   - Address field widths: {frame[5:0], line[9:0], word[8:0]} = 25 bits.
//   - make_addr(): builds the SDRAM word address from its three fields.
//   - wr_state_e: state encoding of the writer FSM.
// -----------------------------------------------------------------------------
package slm_mem_pkg;

  localparam int H_ACTIVE_DEFAULT = 1024;
  localparam int V_ACTIVE_DEFAULT = 768;

  localparam int FRAME_W      = 6;
  localparam int LINE_W       = 10;
  localparam int WORD_W       = 9;
  localparam int SDRAM_ADDR_W = FRAME_W + LINE_W + WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WR,
    ST_DONE
  } wr_state_e;

  function automatic logic [SDRAM_ADDR_W-1:0] make_addr(
    input logic [FRAME_W-1:0] frame,
    input logic [LINE_W-1:0]  line,
    input logic [WORD_W-1:0]  word
  );
    return {frame, line, word};
  endfunction

endpackage

// File: rtl/pixel_pair_packer.sv
// -----------------------------------------------------------------------------
// pixel_pair_packer
// Byte-to-word packer for the frame writer. The controlling FSM says when
// bytes may be accepted (accept) and which half the next byte fills (sel_hi);
// the even pixel lands in word[7:0], the odd pixel in word[15:8]. Filling the
// high byte raises word_valid, which drops again on word_taken.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   accept       FSM is in a byte-collecting state
//   sel_hi       next accepted byte goes to the high half
//   pix_data     byte in
//   pix_valid    byte in is valid
//   pix_ready    byte is accepted when pix_valid && pix_ready
//   byte_fire    handshake of the current cycle
//   word         packed 16-bit word
//   word_valid   both halves filled, word not yet taken
//   word_taken   consumer has written the word out
// -----------------------------------------------------------------------------
module pixel_pair_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        sel_hi,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        byte_fire,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_taken
);

  // A full word blocks further bytes until it has been taken.
  assign pix_ready = accept && !word_valid;
  assign byte_fire = pix_ready && pix_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (byte_fire && sel_hi) begin
        word_valid <= 1'b1;
      end else if (word_taken) begin
        word_valid <= 1'b0;
      end
      if (byte_fire) begin
        if (sel_hi) word[15:8] <= pix_data;
        else        word[7:0]  <= pix_data;
      end
    end
  end

endmodule

// File: rtl/frame_stream_to_sdram.sv
// -----------------------------------------------------------------------------
// frame_stream_to_sdram
// Writer side of the SDRAM frame store. Takes one frame of 8-bit pixels in
// raster order over a valid/ready stream, packs pixel pairs into 16-bit words
// and writes them through an Avalon-MM master to
//   {frame[5:0], line[9:0], word[8:0]}.
// oDONE then gates the reader path.
// Ports:
//   iCLK, iRST_N     SDRAM controller clock, asynchronous active-low reset
//   iSTART           one-cycle frame request, honoured only when idle
//   iFRAME_ID        target frame, latched on an accepted start
//   iPIX_DATA/VALID  pixel stream in; oPIX_READY is the handshake ready
//   iWAIT_REQUEST    Avalon waitrequest from the SDRAM slave
//   oWR_EN/ADDR/DATA Avalon write strobe, word address, word data
//   oBUSY            accepted start until frame completion
//   oDONE            level, set by a complete frame, cleared by next start
// Optional feature (macro FRAME_STREAM_TEST_PATTERN_EN): adds iTEST_MODE; when
// high at the accepted start the stream is ignored and every pixel is
// generated as (column + line + frame)[7:0].
// -----------------------------------------------------------------------------
module frame_stream_to_sdram
  import slm_mem_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
`ifdef FRAME_STREAM_TEST_PATTERN_EN
  input  logic                    iTEST_MODE,
`endif
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iSTART,
  input  logic [FRAME_W-1:0]      iFRAME_ID,
  input  logic [7:0]              iPIX_DATA,
  input  logic                    iPIX_VALID,
  output logic                    oPIX_READY,
  input  logic                    iWAIT_REQUEST,
  output logic                    oWR_EN,
  output logic [SDRAM_ADDR_W-1:0] oWR_ADDR,
  output logic [15:0]             oWR_DATA,
  output logic                    oBUSY,
  output logic                    oDONE
);

  wr_state_e          state, state_next;
  logic [FRAME_W-1:0] frame_q;
  logic [LINE_W-1:0]  line_q;
  logic [WORD_W-1:0]  word_q;
  logic               busy_q, done_q;

  logic               start_ok;
  logic               wr_done;
  logic               last_word, last_line;
  logic               accept, pack_ready, byte_fire, word_valid;
  logic [15:0]        word;
  logic [7:0]         src_data;
  logic               src_valid;

  assign accept    = (state == ST_LO) || (state == ST_HI);
  assign last_word = (word_q == WORD_W'(H_ACTIVE / 2 - 1));
  assign last_line = (line_q == LINE_W'(V_ACTIVE - 1));
  // A write completes on the first edge with the strobe up and no wait.
  assign wr_done   = (state == ST_WR) && !iWAIT_REQUEST;

`ifdef FRAME_STREAM_TEST_PATTERN_EN
  logic       test_q;
  logic [7:0] gen_pix;
  logic [7:0] gen_col;

  // Column of the next pixel is 2*word + (high half); only its low byte
  // matters because the pattern wraps at 8 bits.
  assign gen_col    = {word_q[6:0], state == ST_HI};
  assign gen_pix    = gen_col + line_q[7:0] + {2'b00, frame_q};
  assign src_data   = test_q ? gen_pix : iPIX_DATA;
  assign src_valid  = test_q ? 1'b1    : iPIX_VALID;
  assign oPIX_READY = pack_ready && !test_q;
`else
  assign src_data   = iPIX_DATA;
  assign src_valid  = iPIX_VALID;
  assign oPIX_READY = pack_ready;
`endif

  pixel_pair_packer u_packer (
    .clk        (iCLK),
    .rst_n      (iRST_N),
    .accept     (accept),
    .sel_hi     (state == ST_HI),
    .pix_data   (src_data),
    .pix_valid  (src_valid),
    .pix_ready  (pack_ready),
    .byte_fire  (byte_fire),
    .word       (word),
    .word_valid (word_valid),
    .word_taken (wr_done)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      ST_IDLE: if (iSTART) begin
        start_ok   = 1'b1;
        state_next = ST_LO;
      end
      ST_LO:   if (byte_fire) state_next = ST_HI;
      ST_HI:   if (byte_fire) state_next = ST_WR;
      ST_WR:   if (wr_done) state_next = (last_word && last_line) ? ST_DONE : ST_LO;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      frame_q <= '0;
      line_q  <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FRAME_STREAM_TEST_PATTERN_EN
      test_q  <= 1'b0;
`endif
    end else begin
      if (start_ok) begin
        frame_q <= iFRAME_ID;
        line_q  <= '0;
        word_q  <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
`ifdef FRAME_STREAM_TEST_PATTERN_EN
        test_q  <= iTEST_MODE;
`endif
      end
      if (wr_done) begin
        if (last_word) begin
          word_q <= '0;
          line_q <= line_q + LINE_W'(1);
        end else begin
          word_q <= word_q + WORD_W'(1);
        end
        if (last_word && last_line) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // The strobe follows the WR state directly; address and data come from
  // registers that cannot change while in WR, so they hold under waitrequest.
  assign oWR_EN   = (state == ST_WR);
  assign oWR_ADDR = make_addr(frame_q, line_q, word_q);
  assign oWR_DATA = word;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;

endmodule
